regfile_wr_sched: RTL and testbench

Write-port scheduler for the 16×32 register file. Shares the register file's single write port among `NREQ` writeback requesters (ALU, load unit, debug) with round-robin arbitration and a valid/ready handshake. Also provides a clear sequencer that zeroes every register on command. Sits between the writeback sources and the register file's `wen`/`waddr`/`wdata` inputs; read ports are untouched.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_wr_sched_rr_arbiter.sv | 37 +++
 rtl/regfile_wr_sched.sv | 123 ++++++++++++
 tb/tb_regfile_wr_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-scheduler state encoding.
package regfile_pkg;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NREGS = 2 ** AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_wr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester at or
// after ptr, wrapping modulo NREQ. Grant is one-hot (or zero) plus its index.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx
);

  // Scan requesters starting at ptr; the first valid one wins.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (!found && valid[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the register file: round-robin sharing of the
// single write port among NREQ requesters, plus a clear sequencer that
// zeroes every register. All register-file outputs are registered.
module regfile_wr_sched #(
  parameter int NREQ  = 3,
  parameter int AW    = regfile_pkg::AW,
  parameter int DW    = regfile_pkg::DW,
  parameter int NREGS = regfile_pkg::NREGS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 clr_start,
  output logic                 clr_busy,
  output logic                 clr_done,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_waddr,
  output logic [DW-1:0]        rf_wdata
);

  import regfile_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic [NREQ-1:0] gnt, ready;
  logic [PW-1:0]   gidx;
  logic            wen_nxt, done_nxt;
  logic [AW-1:0]   waddr_nxt;
  logic [DW-1:0]   wdata_nxt;
  logic [AW-1:0]   addr_a [NREQ];
  logic [DW-1:0]   data_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*AW +: AW];
    assign data_a[i] = req_data[i*DW +: DW];
  end

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .valid   (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gidx)
  );

  // Grants are suppressed while reset is asserted, even though state is IDLE.
  assign req_ready = rst_n ? ready : '0;
  assign clr_busy  = (state != IDLE);

  // Next-state and next-output logic; clear has priority over arbitration.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    wen_nxt   = 1'b0;
    done_nxt  = 1'b0;
    waddr_nxt = rf_waddr;
    wdata_nxt = rf_wdata;
    ready     = '0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLEAR;
          wen_nxt   = 1'b1;
          waddr_nxt = '0;
          wdata_nxt = '0;
          cnt_nxt   = AW'(1);
        end else begin
          ready = gnt;
          if (|(req_valid & gnt)) begin
            wen_nxt   = 1'b1;
            waddr_nxt = addr_a[gidx];
            wdata_nxt = data_a[gidx];
            ptr_nxt   = (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
          end
        end
      end
      CLEAR: begin
        wen_nxt   = 1'b1;
        waddr_nxt = cnt;
        wdata_nxt = '0;
        cnt_nxt   = cnt + AW'(1);
        if (cnt == AW'(NREGS-1)) state_nxt = DONE;
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Arbitration pointer, clear counter and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      cnt      <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      clr_done <= 1'b0;
    end else begin
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      rf_wen   <= wen_nxt;
      rf_waddr <= waddr_nxt;
      rf_wdata <= wdata_nxt;
      clr_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Bench for regfile_wr_sched: directed steps plus random traffic, checked
// against a behavioural model of the scheduler and of the register file.
module tb_regfile_wr_sched;

  localparam int NREQ  = 3;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NREGS = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               clr_start;
  logic               clr_busy;
  logic               clr_done;
  logic               rf_wen;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;

  regfile_wr_sched #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREGS(NREGS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  always #5 clk = ~clk;

  // Register file fed by the scheduler's write port.
  logic [DW-1:0] rf_mem [NREGS];
  always @(posedge clk) if (rf_wen) rf_mem[rf_waddr] <= rf_wdata;

  // Reference model state.
  int            m_ptr;
  int            m_clr;      // next address to clear, -1 when not clearing
  bit            m_donep;    // clear finished, completion pulse still owed
  bit            e_wen, e_done;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;
  logic [DW-1:0] m_rf [NREGS];
  logic [NREQ-1:0] last_grant;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int model_grant(logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_clr   = -1;
    m_donep = 0;
    e_wen   = 0;
    e_done  = 0;
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, "_wen"},   rf_wen,    0);
    check({tag, "_waddr"}, rf_waddr,  0);
    check({tag, "_wdata"}, rf_wdata,  0);
    check({tag, "_done"},  clr_done,  0);
    check({tag, "_busy"},  clr_busy,  0);
    check({tag, "_ready"}, req_ready, 0);
  endtask

  // One clock: check the grant mid-cycle, then the registered outputs after the edge.
  task automatic tick();
    int g;
    logic [NREQ-1:0] eready;
    #2;
    eready = '0;
    g = -1;
    if (m_clr < 0 && !m_donep && !clr_start) begin
      g = model_grant(req_valid);
      if (g >= 0) eready[g] = 1'b1;
    end
    check("req_ready", req_ready, eready);
    last_grant = req_ready;
    @(posedge clk);
    #1;
    if (e_wen) m_rf[e_waddr] = e_wdata;
    e_wen  = 0;
    e_done = 0;
    if (m_clr >= 0) begin
      e_wen = 1; e_waddr = AW'(m_clr); e_wdata = '0;
      m_clr++;
      if (m_clr == NREGS) begin m_clr = -1; m_donep = 1; end
    end else if (m_donep) begin
      m_donep = 0; e_done = 1;
    end else if (clr_start) begin
      e_wen = 1; e_waddr = '0; e_wdata = '0; m_clr = 1;
    end else if (g >= 0) begin
      e_wen   = 1;
      e_waddr = req_addr[g*AW +: AW];
      e_wdata = req_data[g*DW +: DW];
      m_ptr   = (g + 1) % NREQ;
    end
    check("rf_wen",   rf_wen,   e_wen);
    check("clr_done", clr_done, e_done);
    check("clr_busy", clr_busy, (m_clr >= 0) || m_donep);
    if (e_wen) begin
      check("rf_waddr", rf_waddr, e_waddr);
      check("rf_wdata", rf_wdata, e_wdata);
    end
  endtask

  task automatic fill(input logic [DW-1:0] base, input bit add_addr);
    req_valid = 3'b001;
    for (int a = 0; a < NREGS; a++) begin
      req_addr[0 +: AW] = AW'(a);
      req_data[0 +: DW] = add_addr ? (base | DW'(a)) : base;
      tick();
    end
    req_valid = '0;
    tick();
  endtask

  logic [NREQ-1:0] rr3 [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [NREQ-1:0] rr2 [4] = '{3'b001, 3'b100, 3'b001, 3'b100};

  initial begin
    int busy_cnt, done_cnt, waited;
    model_reset();
    rst_n     = 1'b0;
    clr_start = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    #1;
    check_reset_outs("rst");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst_hold");
    req_valid = '0;
    rst_n     = 1'b1;
    repeat (3) tick();

    // Single write from requester 1.
    req_valid = 3'b010;
    req_addr[1*AW +: AW] = 4'd5;
    req_data[1*DW +: DW] = 32'hDEADBEEF;
    tick();
    check("single_ready", last_grant, 3'b010);
    req_valid = '0;
    tick();
    check("single_waddr", rf_waddr, 5);
    check("single_wdata", rf_wdata, 32'hDEADBEEF);
    tick();
    check("single_rd5", rf_mem[5], 32'hDEADBEEF);

    // Bring ptr back to 0, then round-robin with all three and with 0/2.
    req_valid = 3'b100;
    tick();
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      req_addr = NREQ*AW'($urandom);
      req_data = {$urandom, $urandom, $urandom};
      tick();
      check("rr_all", last_grant, rr3[i]);
    end
    req_valid = 3'b101;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_0_2", last_grant, rr2[i]);
    end

    // Random traffic with occasional clear requests.
    repeat (300) begin
      req_valid = NREQ'($urandom);
      req_addr  = NREQ*AW'($urandom);
      req_data  = {$urandom, $urandom, $urandom};
      clr_start = ($urandom_range(0, 39) == 0);
      tick();
    end
    clr_start = 1'b0;
    req_valid = '0;
    repeat (20) tick();
    for (int a = 0; a < NREGS; a++) check("rand_rf", rf_mem[a], m_rf[a]);

    // Full clear after filling with ones.
    fill(32'hFFFFFFFF, 1'b0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    busy_cnt = int'(clr_busy);
    done_cnt = 0;
    repeat (20) begin
      tick();
      busy_cnt += int'(clr_busy);
      done_cnt += int'(clr_done);
    end
    check("clr_busy_cycles", busy_cnt, 16);
    check("clr_done_pulses", done_cnt, 1);
    for (int a = 0; a < NREGS; a++) check("clr_rf_zero", rf_mem[a], 0);

    // Clear colliding with a request from requester 0.
    req_valid = 3'b001;
    req_addr[0 +: AW] = 4'd3;
    req_data[0 +: DW] = 32'd7;
    clr_start = 1'b1;
    tick();
    check("coll_no_grant", last_grant, 0);
    clr_start = 1'b0;
    waited = 0;
    while (!clr_done && waited < 40) begin
      tick();
      waited++;
    end
    check("coll_done_seen", clr_done, 1);
    tick();
    check("coll_grant", last_grant, 3'b001);
    req_valid = '0;
    tick();
    tick();
    check("coll_rd3", rf_mem[3], 32'd7);

    // Reset in the middle of a clear.
    fill(32'hA5A50000, 1'b1);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    waited = 0;
    while (!(rf_wen && rf_waddr == 4'd7) && waited < 30) begin
      tick();
      waited++;
    end
    check("mid_reach7", rf_waddr, 7);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outs("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (20) begin
      tick();
      done_cnt += int'(clr_done);
    end
    check("mid_no_done", done_cnt, 0);
    for (int a = 0; a < 7; a++) check("mid_rf_zero", rf_mem[a], 0);
    for (int a = 8; a < NREGS; a++) check("mid_rf_kept", rf_mem[a], 32'hA5A50000 | a);
    for (int a = 0; a < NREGS; a++) check("mid_rf_model", rf_mem[a], m_rf[a]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
